// File: rtl/dili_pkg.sv
// Shared Dilithium NTT constants: modulus, Montgomery factor, twiddle table and engine state type.
package dili_pkg;

    localparam int WIDTH = 32;
    localparam int N     = 256;
    localparam int Q     = 8380417;
    localparam int ROOT  = 1753;
    localparam logic [WIDTH-1:0] QINV = 32'd58728449;

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_e;

    // ZETAS[k] = 2^32 * ROOT^brv8(k) mod Q, centred; ZETAS[0] is left at 0.
    function automatic logic [N*WIDTH-1:0] gen_zetas();
        logic [N*WIDTH-1:0] tab;
        longint base, res, v, mr;
        int br;
        tab = '0;
        mr  = (64'sd1 <<< 32) % longint'(Q);
        for (int k = 1; k < N; k++) begin
            br = 0;
            for (int b = 0; b < 8; b++) br = br | (((k >> b) & 1) << (7 - b));
            base = longint'(ROOT);
            res  = 64'sd1;
            for (int b = 0; b < 8; b++) begin
                if (((br >> b) & 1) != 0) res = (res * base) % longint'(Q);
                base = (base * base) % longint'(Q);
            end
            v = (res * mr) % longint'(Q);
            if (v > longint'(Q / 2)) v = v - longint'(Q);
            tab[k*WIDTH +: WIDTH] = v[WIDTH-1:0];
        end
        return tab;
    endfunction

    localparam logic [N*WIDTH-1:0] ZETAS = gen_zetas();

endpackage

// File: rtl/dili_ntt_bu.sv
// Combinational Cooley-Tukey butterfly with Montgomery reduction of zeta*a_odd.
module dili_ntt_bu
    import dili_pkg::*;
(
    input  logic signed [WIDTH-1:0] a_even_i,
    input  logic signed [WIDTH-1:0] a_odd_i,
    input  logic signed [WIDTH-1:0] zeta_i,
    output logic signed [WIDTH-1:0] a_even_o,
    output logic signed [WIDTH-1:0] a_odd_o
);
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] tq;
    logic signed [2*WIDTH-1:0] diff;
    logic signed [WIDTH-1:0]   tl;
    logic signed [WIDTH-1:0]   t;

    assign prod = 64'(a_odd_i) * 64'(zeta_i);
    assign tl   = prod[WIDTH-1:0] * QINV;
    assign tq   = 64'(tl) * 64'(Q);
    assign diff = prod - tq;
    // Low half of diff is zero by construction, so the upper half is the exact >>> 32.
    assign t    = diff[2*WIDTH-1:WIDTH];

    assign a_even_o = a_even_i + t;
    assign a_odd_o  = a_even_i - t;

endmodule

// File: rtl/dili_ntt_seq.sv
// Sequential forward NTT: stream in 256 coefficients, run 1024 in-place butterflies, stream out.
module dili_ntt_seq
    import dili_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o
);
    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] lay_q, lay_d;
    logic [7:0] start_q, start_d;
    logic [7:0] j_q, j_d;
    logic [7:0] k_q, k_d;

    logic [7:0] len, idx_lo, idx_hi, zidx;
    logic [8:0] next_start;
    logic       in_fire, out_fire, last_in, last_bf, last_out;

    logic signed [WIDTH-1:0] mem  [N];
    logic signed [WIDTH-1:0] zrom [N];
    logic signed [WIDTH-1:0] a_lo, a_hi, b_lo, b_hi, zeta;

    for (genvar g = 0; g < N; g++) begin : g_zrom
        assign zrom[g] = ZETAS[g*WIDTH +: WIDTH];
    end

    // lay_q counts layers, so len = 128 >> layer; j_q is the offset inside the current group.
    assign len        = 8'd128 >> lay_q;
    assign idx_lo     = start_q + j_q;
    assign idx_hi     = idx_lo + len;
    assign zidx       = k_q + 8'd1;
    assign next_start = {1'b0, start_q} + {len, 1'b0};

    assign a_lo = mem[idx_lo];
    assign a_hi = mem[idx_hi];
    assign zeta = zrom[zidx];

    dili_ntt_bu u_bu (
        .a_even_i (a_lo),
        .a_odd_i  (a_hi),
        .zeta_i   (zeta),
        .a_even_o (b_lo),
        .a_odd_o  (b_hi)
    );

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;
    assign last_in  = in_fire && (cnt_q == 10'd255);
    assign last_bf  = (state_q == COMPUTE) && (cnt_q == 10'd1023);
    assign last_out = out_fire && (cnt_q == 10'd255);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= LOAD;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (last_in)  state_d = COMPUTE;
            COMPUTE: if (last_bf)  state_d = UNLOAD;
            UNLOAD:  if (last_out) state_d = LOAD;
            default:               state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == LOAD);
        out_valid_o = (state_q == UNLOAD);
        busy_o      = (state_q == COMPUTE);
        out_data_o  = '0;
        if (state_q == UNLOAD) out_data_o = mem[cnt_q[7:0]];
    end

    always_comb begin
        cnt_d   = cnt_q;
        lay_d   = lay_q;
        start_d = start_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            LOAD: if (in_fire) cnt_d = last_in ? 10'd0 : cnt_q + 10'd1;
            COMPUTE: begin
                cnt_d = cnt_q + 10'd1;
                if (j_q == len - 8'd1) begin
                    j_d = 8'd0;
                    k_d = k_q + 8'd1;
                    if (next_start[8]) begin
                        start_d = 8'd0;
                        lay_d   = lay_q + 3'd1;
                    end else begin
                        start_d = next_start[7:0];
                    end
                end else begin
                    j_d = j_q + 8'd1;
                end
                if (last_bf) begin
                    cnt_d   = 10'd0;
                    lay_d   = 3'd0;
                    start_d = 8'd0;
                    j_d     = 8'd0;
                    k_d     = 8'd0;
                end
            end
            UNLOAD: if (out_fire) cnt_d = last_out ? 10'd0 : cnt_q + 10'd1;
            default: cnt_d = 10'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            lay_q   <= '0;
            start_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
        end else begin
            cnt_q   <= cnt_d;
            lay_q   <= lay_d;
            start_q <= start_d;
            j_q     <= j_d;
            k_q     <= k_d;
        end
    end

    // Coefficient store is deliberately unreset; every operation rewrites all 256 entries.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            mem[cnt_q[7:0]] <= in_data_i;
        end else if (state_q == COMPUTE) begin
            mem[idx_lo] <= b_lo;
            mem[idx_hi] <= b_hi;
        end
    end

endmodule

// File: tb/tb_dili_ntt_seq.sv
// Self-checking bench for dili_ntt_seq against a software-style forward NTT model.
module tb_dili_ntt_seq;

    localparam int QM = 8380417;
    localparam int QI = 58728449;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c_accept = 0;

    int zt    [256];
    int vec   [256];
    int exp_o [256];
    int exp_a [256];
    int got   [256];

    dili_ntt_seq dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int mont(input longint p);
        int t;
        t = int'(p * QI);
        return int'((p - longint'(t) * QM) >>> 32);
    endfunction

    function automatic longint powmod(input longint b, input int e);
        longint r = 1;
        longint x = b;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = (r * x) % QM;
            x = (x * x) % QM;
        end
        return r;
    endfunction

    function automatic void init_zetas();
        longint mr, v;
        int br;
        mr = (longint'(1) <<< 32) % QM;
        zt[0] = 0;
        for (int k = 1; k < 256; k++) begin
            br = 0;
            for (int b = 0; b < 8; b++) br = br | (((k >> b) & 1) << (7 - b));
            v = (powmod(1753, br) * mr) % QM;
            if (v > QM / 2) v = v - QM;
            zt[k] = int'(v);
        end
    endfunction

    // Reference ntt(): vec -> exp_o
    function automatic void ref_ntt();
        int a [256];
        int k, t;
        for (int i = 0; i < 256; i++) a[i] = vec[i];
        k = 0;
        for (int len = 128; len > 0; len = len >> 1) begin
            for (int start = 0; start < 256; start = start + 2 * len) begin
                k++;
                for (int j = start; j < start + len; j++) begin
                    t          = mont(longint'(zt[k]) * a[j + len]);
                    a[j + len] = a[j] - t;
                    a[j]       = a[j] + t;
                end
            end
        end
        for (int i = 0; i < 256; i++) exp_o[i] = a[i];
    endfunction

    function automatic void rand_vec();
        for (int i = 0; i < 256; i++)
            vec[i] = int'($urandom_range(0, 2 * QM - 2)) - (QM - 1);
    endfunction

    task automatic send_poly(input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < 256 && guard < 5000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = vec[i];
            if (in_valid && in_ready) begin
                @(posedge clk); #1;
                if (i == 255) c_accept = cyc;
                i++;
            end else begin
                @(posedge clk); #1;
            end
            guard++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (i != 256) begin
            n_fail++;
            $display("FAIL load_count: accepted %0d, required 256", i);
        end
    endtask

    task automatic wait_out(output int nb, output int lat);
        int guard = 0;
        nb = 0;
        while (!out_valid && guard < 3000) begin
            if (busy) nb++;
            @(posedge clk); #1;
            guard++;
        end
        lat = cyc - c_accept;
    endtask

    task automatic recv_poly(input bit stall);
        int i = 0;
        int guard = 0;
        bit held = 0;
        logic [31:0] held_data = '0;
        while (i < 256 && guard < 5000) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL unload_valid: out_valid=%b at index %0d, required 1", out_valid, i);
            end
            if (held) begin
                n_checks++;
                if (out_data !== held_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: out_data=%0d, required %0d", out_data, held_data);
                end
            end
            if (out_valid && out_ready) begin
                got[i] = out_data;
                i++;
                held = 0;
            end else begin
                held = 1;
                held_data = out_data;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (i != 256) begin
            n_fail++;
            $display("FAIL unload_count: received %0d, required 256", i);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_unload: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: %b, required 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: %b, required 0", out_valid); end
        n_checks++;
        if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: %0d, required 0", out_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b, required 0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero();
        int nb, lat, bad;
        for (int i = 0; i < 256; i++) vec[i] = 0;
        send_poly(1'b0);
        wait_out(nb, lat);
        n_checks++;
        if (nb != 1024) begin n_fail++; $display("FAIL zero_busy_cycles: %0d, required 1024", nb); end
        recv_poly(1'b0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (got[i] != 0) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL zero_data: %0d nonzero outputs, required 0", bad); end
    endtask

    task automatic test_impulse();
        int nb, lat, bad, first;
        for (int i = 0; i < 256; i++) vec[i] = 0;
        vec[0] = 1;
        send_poly(1'b0);
        wait_out(nb, lat);
        recv_poly(1'b0);
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) if (got[i] != 1) begin if (bad == 0) first = i; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL impulse_data: %0d bad, idx %0d got %0d, required 1", bad, first, got[first]);
        end
    endtask

    task automatic test_random();
        int nb, lat, bad, first;
        rand_vec();
        ref_ntt();
        send_poly(1'b0);
        wait_out(nb, lat);
        // out_valid is first seen just after edge c+1024, i.e. in cycle c+1025
        n_checks++;
        if (lat != 1024) begin n_fail++; $display("FAIL rand_latency: %0d edges after accept, required 1024", lat); end
        n_checks++;
        if (nb != 1024) begin n_fail++; $display("FAIL rand_busy_cycles: %0d, required 1024", nb); end
        recv_poly(1'b0);
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) if (got[i] != exp_o[i]) begin if (bad == 0) first = i; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rand_data: %0d bad, idx %0d got %0d, required %0d", bad, first, got[first], exp_o[first]);
        end
    endtask

    task automatic test_stall();
        int nb, lat, bad, first;
        send_poly(1'b1);
        wait_out(nb, lat);
        n_checks++;
        if (lat != 1024) begin n_fail++; $display("FAIL stall_latency: %0d, required 1024", lat); end
        recv_poly(1'b1);
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) if (got[i] != exp_o[i]) begin if (bad == 0) first = i; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_data: %0d bad, idx %0d got %0d, required %0d", bad, first, got[first], exp_o[first]);
        end
    endtask

    task automatic test_abort();
        int nb, lat, bad, first;
        rand_vec();
        send_poly(1'b0);
        repeat (500) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre_busy: %b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: out_valid=%b in_ready=%b busy=%b, required 0/1/0", out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_vec();
        ref_ntt();
        send_poly(1'b0);
        wait_out(nb, lat);
        n_checks++;
        if (lat != 1024) begin n_fail++; $display("FAIL abort_latency: %0d, required 1024", lat); end
        recv_poly(1'b0);
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) if (got[i] != exp_o[i]) begin if (bad == 0) first = i; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_data: %0d bad, idx %0d got %0d, required %0d", bad, first, got[first], exp_o[first]);
        end
    endtask

    task automatic test_back_to_back();
        int nb, lat, bad, first;
        rand_vec();
        ref_ntt();
        for (int i = 0; i < 256; i++) exp_a[i] = exp_o[i];
        send_poly(1'b0);
        wait_out(nb, lat);
        recv_poly(1'b0);
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) if (got[i] != exp_a[i]) begin if (bad == 0) first = i; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_first_data: %0d bad, idx %0d got %0d, required %0d", bad, first, got[first], exp_a[first]);
        end
        rand_vec();
        ref_ntt();
        send_poly(1'b0);
        wait_out(nb, lat);
        n_checks++;
        if (lat != 1024) begin n_fail++; $display("FAIL b2b_latency: %0d, required 1024", lat); end
        recv_poly(1'b0);
        bad = 0; first = 0;
        for (int i = 0; i < 256; i++) if (got[i] != exp_o[i]) begin if (bad == 0) first = i; bad++; end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL b2b_second_data: %0d bad, idx %0d got %0d, required %0d", bad, first, got[first], exp_o[first]);
        end
    endtask

    initial begin
        init_zetas();
        test_reset();
        test_zero();
        test_impulse();
        test_random();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dili_ntt_seq.md
# dili_ntt_seq

Sequential forward NTT engine for the Dilithium datapath: the forward-direction counterpart of the combinational inverse-NTT layer. It accepts a 256-coefficient polynomial over a valid/ready stream and performs all 8 Cooley-Tukey layers with one Montgomery butterfly per cycle. It then streams the transformed polynomial out, in the NTT-domain order expected by the pointwise multiplier and the inverse NTT.

## Interface
- WIDTH, 32: coefficient width, signed two's complement.
- Q, 8380417: modulus.
- QINV, 58728449: Q^-1 mod 2^32, used for Montgomery reduction.
- N, 256: polynomial length; only 256 is supported.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  input coefficient valid.
- in_ready_o  out  1  engine accepts a coefficient this cycle.
- in_data_i  in  WIDTH  coefficient a[i], delivered in index order 0..255.
- out_valid_o  out  1  output coefficient valid.
- out_ready_i  in  1  downstream accepts.
- out_data_o  out  WIDTH  transformed coefficient â[i], delivered in index order 0..255.
- busy_o  out  1  high in COMPUTE.

## Operation
- FSM states: LOAD, COMPUTE, UNLOAD. Reset enters LOAD.
- Reset values:
  - in_ready_o=1 (follows LOAD), out_valid_o=0, out_data_o=0, busy_o=0.
  - All counters are 0. The coefficient array is not reset.
- LOAD:
  - in_ready_o=1.
  - On in_valid_i & in_ready_o, write a[cnt]=in_data_i and increment cnt.
  - When the 256th coefficient is accepted, go to COMPUTE and clear the counters.
- COMPUTE, loop structure:
  - len starts at 128 and halves down to 1.
  - For each len, start steps 0, 2·len, … <256.
  - k is pre-incremented per group: zeta=ZETAS[++k], with k starting at 0, so the first zeta used is ZETAS[1].
  - Within a group, j runs from start to start+len-1.
- COMPUTE, butterfly (one per cycle, result written the same cycle):
  - t = mont(zeta·a[j+len]).
  - a[j+len] = a[j] − t.
  - a[j] = a[j] + t.
- COMPUTE length and exit:
  - 128 butterflies per layer × 8 layers = 1024 cycles.
  - After the last butterfly (len=1, j=254), go to UNLOAD.
- Montgomery reduction mont(p):
  - p is the 64-bit signed product.
  - t = signed low 32 bits of (p[31:0]·QINV).
  - r = (p − t·Q) >>> 32, truncated to WIDTH.
- Arithmetic rules:
  - Add and subtract wrap at WIDTH bits.
  - No final reduction to [0,Q); output matches the reference software ntt() bit-exactly.
- UNLOAD:
  - out_valid_o=1 and out_data_o=a[cnt].
  - On out_valid_o & out_ready_i, increment cnt.
  - After the 256th handshake, return to LOAD with cnt=0.
- Input is ignored outside LOAD (in_ready_o=0). out_valid_o is 0 outside UNLOAD.
- Backpressure: while out_ready_i=0, out_data_o and out_valid_o hold stable.
- rst_ni low in any state aborts the operation immediately. Partial data is discarded and the next operation starts with a fresh LOAD.

## Timing
- Input throughput: 1 coefficient/cycle. No bubbles are required; gaps in in_valid_i are tolerated.
- COMPUTE latency: exactly 1024 cycles.
  - If the 256th input is accepted at edge c, busy_o is high for edges c+1..c+1024.
  - out_valid_o rises after edge c+1024, so the first output is available in cycle c+1025.
- Output throughput: 1 coefficient/cycle when out_ready_i is held high. Full unload takes 256 cycles.
- Back-to-back transfers: the first cycle after the final output handshake is LOAD with in_ready_o=1.
- Total latency with an unstalled stream: 256 + 1024 + 256 cycles per polynomial. There is no overlap between polynomials.

## Structure
- Shared package dili_pkg holds:
  - Q, QINV, N, WIDTH.
  - The 256-entry signed ZETAS constant table (Montgomery-domain roots; ZETAS[0]=0 is unused).
  - The state enum typedef {LOAD, COMPUTE, UNLOAD}.
- Sub-module dili_ntt_bu: combinational Cooley-Tukey butterfly.
  - Inputs: a_even_i, a_odd_i, zeta_i.
  - Outputs: a_even_o, a_odd_o.
  - Contains the Montgomery reduction.
  - Forms the mirror pair with dili_intt_bu.
- Top level contains:
  - The FSM and the len/start/j/k counters.
  - The 256×WIDTH register array, with one read pair and one write pair per cycle.

## Test plan
- All-zero input → 256 zero outputs; busy_o is high for exactly 1024 cycles.
- Impulse a[0]=1, rest 0 → every output coefficient equals 1.
- Random input with |a[i]|<Q, out_ready_i held 1 → bit-exact match with the reference software ntt(). Output start lands exactly 1025 cycles after the last input accept.
- Same random vector with random in_valid_i gaps and out_ready_i toggling → identical results. out_data_o is stable while stalled, and no coefficients are dropped or duplicated.
- rst_ni asserted mid-COMPUTE (e.g. after 500 butterflies) → out_valid_o=0 and in_ready_o=1 immediately. A following full polynomial produces correct results.
- Two polynomials back-to-back → the second LOAD begins the cycle after the 256th output handshake, and both results are correct.
